led_fade_sequencer: RTL and testbench

Parametrised multi-channel PWM LED driver with a built-in fade sequencer and a perceptual (square-law) brightness correction. It replaces the fixed three-channel fader in board top levels. It walks a triangle brightness ramp through each channel in turn and then through all channels together, and also supports breathe, static-duty and off modes. It sits between the board clock/reset and the LED pins, with an optional host-driven mode/duty interface.

---
 rtl/led_fade_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_led_fade_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_sequencer.sv
// ---------------------------------------------------------------------------
// led_fade_sequencer
//
// Multi-channel PWM LED driver with a built-in fade sequencer. A triangle
// brightness ramp is walked through each channel in turn, then through all
// channels together. Breathe, static-duty and off modes are also available.
//
// Optional feature macro: LED_GAMMA_EN
//   defined   -> square-law brightness correction d = (raw*raw) >> PWM_BITS,
//                one extra pipeline stage (led latency 2 cycles)
//   undefined -> d = raw, led latency 1 cycle
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   en         in   run enable; low freezes all state and forces LEDs unlit
//   mode       in   0 sequence, 1 breathe, 2 static, 3 off
//   duty_in    in   static duty, channel i at [i*PWM_BITS +: PWM_BITS]
//   led        out  pin drive (low = lit when ACTIVE_LOW)
//   phase      out  sequence phase, CHANNELS means all channels
//   phase_wrap out  one-cycle pulse when the sequence returns to phase 0
// ---------------------------------------------------------------------------
module led_fade_sequencer #(
  parameter int CHANNELS   = 3,
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 18,
  parameter int ACTIVE_LOW = 1,
  localparam int PHASE_W   = $clog2(CHANNELS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic [CHANNELS*PWM_BITS-1:0] duty_in,
  output logic [CHANNELS-1:0]          led,
  output logic [PHASE_W-1:0]           phase,
  output logic                         phase_wrap
);

  typedef enum logic [1:0] {
    MODE_SEQ     = 2'd0,
    MODE_BREATHE = 2'd1,
    MODE_STATIC  = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
  localparam logic [PHASE_W-1:0]  PHASE_ALL = PHASE_W'(CHANNELS);
  localparam logic [CHANNELS-1:0] UNLIT     = {CHANNELS{ACTIVE_LOW != 0}};

  logic [PWM_BITS-1:0]          pwm_cnt_q, pwm_cnt_d;
  logic [STEP_DIV-1:0]          presc_q, presc_d;
  mode_e                        mode_q, mode_d;
  logic [CHANNELS*PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0]          b_q, b_d;
  logic                         dir_q, dir_d;
  logic [PHASE_W-1:0]           phase_q, phase_d;
  logic                         wrap_q, wrap_d;
  logic [CHANNELS-1:0]          led_q;

  logic boundary, tick, ramp_mode, mode_change;
  mode_e mode_in;

  assign mode_in     = mode_e'(mode);
  assign boundary    = (pwm_cnt_q == MAX);
  // STEP_DIV >= PWM_BITS, so a tick always lands on a period boundary.
  assign tick        = &presc_q;
  assign ramp_mode   = (mode_q == MODE_SEQ) || (mode_q == MODE_BREATHE);
  assign mode_change = boundary && (mode_in != mode_q);

  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    presc_d   = presc_q;
    mode_d    = mode_q;
    duty_d    = duty_q;
    b_d       = b_q;
    dir_d     = dir_q;
    phase_d   = phase_q;
    wrap_d    = 1'b0;
    if (en) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      presc_d   = presc_q + 1'b1;
      // Mode and duty only move at period boundaries so no PWM period is cut.
      if (boundary) begin
        mode_d = mode_in;
        duty_d = duty_in;
      end
      if (mode_change) begin
        // A mode change swallows any coincident tick.
        if ((mode_in == MODE_SEQ) || (mode_in == MODE_BREATHE)) begin
          phase_d = (mode_in == MODE_BREATHE) ? PHASE_ALL : '0;
          if (!ramp_mode) begin
            // Fresh ramp when coming from static/off; prescaler realigns here.
            b_d     = '0;
            dir_d   = 1'b0;
            presc_d = '0;
          end
        end
      end else if (tick && ramp_mode) begin
        if (!dir_q) begin
          b_d = b_q + 1'b1;
          if (b_q == MAX - 1'b1) dir_d = 1'b1;
        end else begin
          b_d = b_q - 1'b1;
          if (b_q == PWM_BITS'(1)) begin
            dir_d = 1'b0;
            // End of one full ramp: advance the sequence (breathe holds).
            if (mode_q == MODE_SEQ) begin
              if (phase_q == PHASE_ALL) begin
                phase_d = '0;
                wrap_d  = 1'b1;
              end else begin
                phase_d = phase_q + 1'b1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      presc_q   <= '0;
      mode_q    <= MODE_OFF;
      duty_q    <= '0;
      b_q       <= '0;
      dir_q     <= 1'b0;
      phase_q   <= '0;
      wrap_q    <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      presc_q   <= presc_d;
      mode_q    <= mode_d;
      duty_q    <= duty_d;
      b_q       <= b_d;
      dir_q     <= dir_d;
      phase_q   <= phase_d;
      wrap_q    <= wrap_d;
    end
  end

  // Raw duty per channel.
  logic [CHANNELS-1:0][PWM_BITS-1:0] raw_c;
  logic [CHANNELS-1:0][PWM_BITS-1:0] duty_eff;
  logic [PWM_BITS-1:0]               cnt_eff;
  logic [CHANNELS-1:0]               lit_c;

  genvar gi;
  for (gi = 0; gi < CHANNELS; gi++) begin : g_raw
    logic                sel;
    logic [PWM_BITS-1:0] raw;
    assign sel = (phase_q == PHASE_W'(gi)) || (phase_q == PHASE_ALL);
    always_comb begin
      case (mode_q)
        MODE_SEQ:     raw = sel ? b_q : '0;
        MODE_BREATHE: raw = b_q;
        MODE_STATIC:  raw = duty_q[gi*PWM_BITS +: PWM_BITS];
        default:      raw = '0;
      endcase
    end
    assign raw_c[gi] = raw;
  end

`ifdef LED_GAMMA_EN
  logic [CHANNELS-1:0][PWM_BITS-1:0] gamma_c, duty_pipe_q;
  logic [PWM_BITS-1:0]               cnt_pipe_q;

  for (gi = 0; gi < CHANNELS; gi++) begin : g_gamma
    logic [2*PWM_BITS-1:0] sq;
    assign sq          = {{PWM_BITS{1'b0}}, raw_c[gi]} * {{PWM_BITS{1'b0}}, raw_c[gi]};
    assign gamma_c[gi] = PWM_BITS'(sq >> PWM_BITS);
  end

  // The counter copy travels with the corrected duty so the compare stays
  // aligned; both hold while disabled so resume is seamless.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_pipe_q <= '0;
      cnt_pipe_q  <= '0;
    end else if (en) begin
      duty_pipe_q <= gamma_c;
      cnt_pipe_q  <= pwm_cnt_q;
    end
  end

  assign duty_eff = duty_pipe_q;
  assign cnt_eff  = cnt_pipe_q;
`else
  assign duty_eff = raw_c;
  assign cnt_eff  = pwm_cnt_q;
`endif

  for (gi = 0; gi < CHANNELS; gi++) begin : g_lit
    assign lit_c[gi] = (duty_eff[gi] > cnt_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= UNLIT;
    end else begin
      led_q <= en ? (lit_c ^ UNLIT) : UNLIT;
    end
  end

  assign led        = led_q;
  assign phase      = phase_q;
  assign phase_wrap = wrap_q;

endmodule

// File: tb/tb_led_fade_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_fade_sequencer
//
// Self-checking bench for led_fade_sequencer with CHANNELS=3, PWM_BITS=4,
// STEP_DIV=4, ACTIVE_LOW=1. Honours LED_GAMMA_EN (latency and expected duty).
// `e` counts enabled clock edges since reset; after edge e the DUT counter
// equals e mod 16 and the led sample reflects the state after edge e-LAT.
// ---------------------------------------------------------------------------
module tb_led_fade_sequencer;

  localparam int CH = 3;
  localparam int PB = 4;
  localparam int SD = 4;
`ifdef LED_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'd3;
  logic [CH*PB-1:0] duty_in = '0;
  logic [CH-1:0]    led;
  logic [1:0]       phase;
  logic             phase_wrap;

  led_fade_sequencer #(
    .CHANNELS(CH), .PWM_BITS(PB), .STEP_DIV(SD), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .duty_in(duty_in),
    .led(led), .phase(phase), .phase_wrap(phase_wrap)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int e = 0;

  typedef struct {
    int duty[3];
    int mid[3];
    bit change_mid;
    int exp[3];
  } vec_t;

  typedef struct {
    int l[3];
  } exp_t;

  vec_t vecs[5];
  exp_t sb_q[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) e = 0;
    else if (en) e++;
    #1;
  endtask

  function automatic int exp_lit(input int d);
`ifdef LED_GAMMA_EN
    return (d * d) >> PB;
`else
    return d;
`endif
  endfunction

  // Brightness after k ticks of a 0..15..0 triangle (30 ticks per ramp).
  function automatic int tri_b(input int k);
    int m;
    m = k % 30;
    return (m <= 15) ? m : 30 - m;
  endfunction

  function automatic logic [CH*PB-1:0] pack3(input int a, input int b, input int c);
    return {c[3:0], b[3:0], a[3:0]};
  endfunction

  function automatic bit is_lit(input logic [CH-1:0] l, input int ch);
    return (l & (3'b001 << ch)) == 3'b000;
  endfunction

  initial begin
    int bad;
    int cnt[3];
    int s, j, p, ex, exp_ph;
    int wraps, wrap_at, phase_bad;
    bit switched, gap_done;
    exp_t got;

    // ---------------- reset ----------------
    repeat (3) step();
    check("rst_led", int'(led), 7);
    check("rst_phase", int'(phase), 0);
    check("rst_wrap", int'(phase_wrap), 0);
    $display("[TB] reset: led=%b phase=%0d wrap=%0d", led, phase, phase_wrap);

    // ---------------- mode 3 (off) ----------------
    rst = 1'b0; en = 1'b1; mode = 2'd3;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (led != 3'b111 || phase != 2'd0 || phase_wrap) bad++;
    end
    check("off_bad_cycles", bad, 0);
    $display("[TB] mode off: 100 cycles, bad=%0d", bad);

    // ---------------- mode 2 (static) table ----------------
    vecs[0].duty = '{0, 8, 15};  vecs[0].change_mid = 1'b0; vecs[0].mid = '{0, 0, 0};
    vecs[1].duty = '{1, 2, 3};   vecs[1].change_mid = 1'b0; vecs[1].mid = '{0, 0, 0};
    vecs[2].duty = '{15, 15, 15}; vecs[2].change_mid = 1'b0; vecs[2].mid = '{0, 0, 0};
    vecs[3].duty = '{5, 9, 12};  vecs[3].change_mid = 1'b1; vecs[3].mid = '{15, 0, 3};
    vecs[4].duty = '{15, 0, 3};  vecs[4].change_mid = 1'b0; vecs[4].mid = '{0, 0, 0};
    for (int v = 0; v < 5; v++)
      for (int ch = 0; ch < 3; ch++)
        vecs[v].exp[ch] = exp_lit(vecs[v].duty[ch]);

    for (int v = 0; v < 5; v++) begin
      exp_t ex_rec;
      mode = 2'd2;
      duty_in = pack3(vecs[v].duty[0], vecs[v].duty[1], vecs[v].duty[2]);
      for (int ch = 0; ch < 3; ch++) ex_rec.l[ch] = vecs[v].exp[ch];
      sb_q.push_back(ex_rec);
      do step(); while (e % 16 != 0);
      repeat (LAT) step();
      cnt = '{0, 0, 0};
      for (int c = 0; c < 16; c++) begin
        if (c == 6 && vecs[v].change_mid)
          duty_in = pack3(vecs[v].mid[0], vecs[v].mid[1], vecs[v].mid[2]);
        for (int ch = 0; ch < 3; ch++) if (is_lit(led, ch)) cnt[ch]++;
        step();
      end
      got = sb_q.pop_front();
      for (int ch = 0; ch < 3; ch++)
        check($sformatf("static_v%0d_ch%0d_lit", v, ch), cnt[ch], got.l[ch]);
      $display("[TB] static v%0d: lit %0d/%0d/%0d expected %0d/%0d/%0d", v,
               cnt[0], cnt[1], cnt[2], got.l[0], got.l[1], got.l[2]);
    end

    // ---------------- mode 0 (sequence) from reset ----------------
    rst = 1'b1; step();
    rst = 1'b0; en = 1'b1; mode = 2'd0;
    cnt = '{0, 0, 0};
    wraps = 0; wrap_at = -1; phase_bad = 0;
    while (e < 16 + 16 * 124 + LAT) begin
      step();
      exp_ph = (e < 16) ? 0 : ((e - 16) / 480) % 4;
      if (int'(phase) != exp_ph) phase_bad++;
      if (phase_wrap) begin
        wraps++;
        wrap_at = e;
      end
      s = e - LAT - 16;
      if (s >= 0) begin
        for (int ch = 0; ch < 3; ch++) if (is_lit(led, ch)) cnt[ch]++;
        if (s % 16 == 15) begin
          j = s / 16;
          p = (j / 30) % 4;
          for (int ch = 0; ch < 3; ch++) begin
            ex = (p == 3 || p == ch) ? exp_lit(tri_b(j)) : 0;
            check($sformatf("seq_period%0d_ch%0d_lit", j, ch), cnt[ch], ex);
          end
          cnt = '{0, 0, 0};
          if (j % 30 == 29) $display("[TB] seq: phase %0d ramp done at e=%0d", p, e);
        end
      end
    end
    check("seq_phase_bad_cycles", phase_bad, 0);
    check("seq_wrap_pulses", wraps, 1);
    check("seq_wrap_cycle", wrap_at, 1936);
    $display("[TB] seq: wraps=%0d at e=%0d phase_bad=%0d", wraps, wrap_at, phase_bad);

    // ---------------- mode 1 (breathe), switch to 0, en gap ----------------
    rst = 1'b1; step();
    rst = 1'b0; en = 1'b1; mode = 2'd1;
    cnt = '{0, 0, 0};
    phase_bad = 0; wraps = 0; switched = 1'b0; gap_done = 1'b0;
    while (e < 16 + 16 * 17 + LAT) begin
      step();
      exp_ph = (e < 16) ? 0 : ((e < 192) ? 3 : 0);
      if (int'(phase) != exp_ph) phase_bad++;
      if (phase_wrap) wraps++;
      s = e - LAT - 16;
      if (s >= 0) begin
        for (int ch = 0; ch < 3; ch++) if (is_lit(led, ch)) cnt[ch]++;
        if (s % 16 == 15) begin
          j = s / 16;
          for (int ch = 0; ch < 3; ch++) begin
            if (j <= 10) ex = exp_lit(tri_b(j));
            else ex = (ch == 0) ? exp_lit(tri_b(j - 1)) : 0;
            check($sformatf("brth_period%0d_ch%0d_lit", j, ch), cnt[ch], ex);
          end
          cnt = '{0, 0, 0};
        end
      end
      if (e == 181 && !switched) begin
        mode = 2'd0;
        switched = 1'b1;
        $display("[TB] breathe: switch to sequence requested at e=%0d", e);
      end
      if (e == 247 && !gap_done) begin
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
          step();
          if (led != 3'b111 || phase != 2'd0 || phase_wrap) bad++;
        end
        check("en_gap_bad_cycles", bad, 0);
        $display("[TB] en gap: 100 cycles, bad=%0d", bad);
        en = 1'b1;
        gap_done = 1'b1;
      end
    end
    check("brth_phase_bad_cycles", phase_bad, 0);
    check("brth_wrap_pulses", wraps, 0);
    $display("[TB] breathe/switch: phase_bad=%0d wraps=%0d", phase_bad, wraps);

    // 0 -> 1 mid-ramp: phase jumps to all-channels at the boundary.
    mode = 2'd1;
    do step(); while (e % 16 != 0);
    check("seq_to_brth_phase", int'(phase), 3);
    repeat (20) step();
    $display("[TB] breathe again: phase=%0d led=%b", phase, led);

    // ---------------- reset mid-ramp ----------------
    rst = 1'b1; step();
    check("midrst_led", int'(led), 7);
    check("midrst_phase", int'(phase), 0);
    check("midrst_wrap", int'(phase_wrap), 0);
    $display("[TB] mid-ramp reset: led=%b phase=%0d wrap=%0d", led, phase, phase_wrap);

    // First sampled mode only takes effect at the first boundary.
    rst = 1'b0; en = 1'b1; mode = 2'd2; duty_in = pack3(15, 15, 15);
    bad = 0;
    repeat (15 + LAT) begin
      step();
      if (led != 3'b111) bad++;
    end
    check("first_mode_unlit_cycles", bad, 0);
    step();
    check("first_mode_lit", int'(led), 0);
    $display("[TB] first boundary: early lit=%0d led=%b", bad, led);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
